twiddle_quarter_gen: RTL and testbench

Pipelined, parametrised twiddle-factor generator for the runtime-sizeable FFT core. It stores only the first quarter-wave of cos/sin and rebuilds any W_N^k for N = 4 … 2^MAX_LOG2N using quadrant symmetry. It supports forward and inverse (conjugated) twiddles, runtime FFT size selection, a clock-enable stall and one result per cycle. It sits between the FFT address generator and the butterfly multiplier, replacing the fixed half-wave twiddle ROM.

---
 rtl/twiddle_quarter_gen.sv | 163 ++++++++++++++++
 tb/tb_twiddle_quarter_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_quarter_gen.sv
// twiddle_quarter_gen
//   Pipelined twiddle-factor generator. Only the first quarter-wave of
//   cos/sin is stored; any W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) for
//   N = 4 .. 2^MAX_LOG2N is rebuilt from quadrant symmetry. Forward or
//   conjugated (inverse) output. Three ce-qualified cycles of latency,
//   one result per cycle.
//
//   The quarter-wave table (2^(MAX_LOG2N-2) entries, {cos, sin} in
//   Q1.(PART-1), 1.0 saturated to max positive) is computed at elaboration
//   with integer fixed-point Taylor series. It is therefore a constant ROM:
//   it is untouched by reset and needs no external hex image.
//   Supports DATA_WIDTH even, PART = DATA_WIDTH/2 in 2..30.
//
// Ports
//   clk          clock
//   rst          asynchronous active-high reset
//   i_ce         pipeline clock enable; low freezes every stage
//   i_in_valid   request strobe (sampled when i_ce=1)
//   i_k          twiddle index; bits at or above log2n ignored
//   i_log2n      FFT size select; clamped to [2, MAX_LOG2N]
//   i_inverse    1 = return conj(W_N^k)
//   o_out_valid  o_twiddle_q valid
//   o_twiddle_q  {Re, Im}, each PART bits signed
//   o_out_err    log2n was clamped for this result
module twiddle_quarter_gen #(
  parameter int MAX_LOG2N  = 9,
  parameter int DATA_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ce,
  input  logic                  i_in_valid,
  input  logic [MAX_LOG2N-1:0]  i_k,
  input  logic [3:0]            i_log2n,
  input  logic                  i_inverse,
  output logic                  o_out_valid,
  output logic [DATA_WIDTH-1:0] o_twiddle_q,
  output logic                  o_out_err
);

  localparam int PART  = DATA_WIDTH / 2;
  localparam int RW    = MAX_LOG2N - 2;
  localparam int DEPTH = 1 << RW;
  localparam int FB    = 30;               // fraction bits of the table math
  localparam int SH    = FB - (PART - 1);  // rounding shift down to Q1.(PART-1)
  localparam longint PI_Q = 64'sd3373259426; // pi * 2^30
  localparam logic [3:0] L_MAX = 4'(MAX_LOG2N);

  // {cos, sin} of 2*pi*idx/2^MAX_LOG2N. Angle <= pi/2, so 12 terms of each
  // series are far below 1 LSB of truncation error; all products stay < 2^63.
  function automatic logic [DATA_WIDTH-1:0] f_rom_entry(input int idx);
    longint th, th2, tc, ts, c, s, maxp;
    logic [PART-1:0] cq, sq;
    th  = (PI_Q * longint'(idx)) >>> (MAX_LOG2N - 1);
    th2 = (th * th) >>> FB;
    tc  = longint'(1) <<< FB;
    ts  = th;
    c   = 0;
    s   = 0;
    for (int n = 0; n < 12; n++) begin
      c  = c + tc;
      s  = s + ts;
      tc = -((tc * th2) >>> FB) / longint'((2*n + 1) * (2*n + 2));
      ts = -((ts * th2) >>> FB) / longint'((2*n + 2) * (2*n + 3));
    end
    maxp = (longint'(1) <<< (PART - 1)) - 1;
    c = (c + (longint'(1) <<< (SH - 1))) >>> SH;
    s = (s + (longint'(1) <<< (SH - 1))) >>> SH;
    // 1.0 saturates to max positive so later negation cannot overflow
    if (c > maxp) c = maxp;
    if (s > maxp) s = maxp;
    if (c < 0)    c = 0;
    if (s < 0)    s = 0;
    cq = c[PART-1:0];
    sq = s[PART-1:0];
    return {cq, sq};
  endfunction

  logic [DATA_WIDTH-1:0] w_rom [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [DATA_WIDTH-1:0] ENTRY = f_rom_entry(g);
    assign w_rom[g] = ENTRY;
  end

  // ---- stage 1: clamp size, scale k onto the full-size circle ----
  logic [3:0]           w_l, w_sh;
  logic                 w_err;
  logic [MAX_LOG2N-1:0] w_mask, w_m;

  always_comb begin
    w_l   = i_log2n;
    w_err = 1'b0;
    if (i_log2n < 4'd2) begin
      w_l   = 4'd2;
      w_err = 1'b1;
    end else if (i_log2n > L_MAX) begin
      w_l   = L_MAX;
      w_err = 1'b1;
    end
  end

  assign w_sh   = L_MAX - w_l;
  assign w_mask = {MAX_LOG2N{1'b1}} >> w_sh;   // k mod 2^L
  assign w_m    = (i_k & w_mask) << w_sh;      // index on the 2^MAX_LOG2N circle

  // ---- stage 3 mapping from stage-2 registers ----
  logic [1:0]            r_q1, r_q2;
  logic [RW-1:0]         r_r1;
  logic                  r_inv1, r_inv2, r_err1, r_err2;
  logic [DATA_WIDTH-1:0] r_cs2;
  logic [1:0]            r_vld_pipe;           // [0]=stage1, [1]=stage2
  logic [PART-1:0]       w_c, w_s, w_nc, w_ns, w_re, w_im, w_im_fwd;

  assign w_c  = r_cs2[2*PART-1:PART];
  assign w_s  = r_cs2[PART-1:0];
  assign w_nc = -w_c;
  assign w_ns = -w_s;

  always_comb begin
    w_re     = w_c;
    w_im_fwd = w_ns;
    case (r_q2)
      2'd0: begin w_re = w_c;  w_im_fwd = w_ns; end
      2'd1: begin w_re = w_ns; w_im_fwd = w_nc; end
      2'd2: begin w_re = w_nc; w_im_fwd = w_s;  end
      2'd3: begin w_re = w_s;  w_im_fwd = w_c;  end
      default: ;
    endcase
    w_im = r_inv2 ? -w_im_fwd : w_im_fwd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_q1        <= '0;
      r_r1        <= '0;
      r_inv1      <= 1'b0;
      r_err1      <= 1'b0;
      r_q2        <= '0;
      r_inv2      <= 1'b0;
      r_err2      <= 1'b0;
      r_cs2       <= '0;
      o_out_valid <= 1'b0;
      o_out_err   <= 1'b0;
      o_twiddle_q <= '0;
    end else if (i_ce) begin
      r_vld_pipe  <= {r_vld_pipe[0], i_in_valid};
      r_q1        <= w_m[MAX_LOG2N-1 -: 2];
      r_r1        <= w_m[RW-1:0];
      r_inv1      <= i_inverse;
      r_err1      <= w_err;
      r_q2        <= r_q1;
      r_inv2      <= r_inv1;
      r_err2      <= r_err1;
      r_cs2       <= w_rom[r_r1];
      o_out_valid <= r_vld_pipe[1];
      o_out_err   <= r_vld_pipe[1] & r_err2;
      // twiddle_q keeps the last result while no valid result arrives
      if (r_vld_pipe[1]) o_twiddle_q <= {w_re, w_im};
    end
  end

endmodule

// File: tb/tb_twiddle_quarter_gen.sv
module tb_twiddle_quarter_gen;
  localparam int MAXL = 9;
  localparam int DW   = 48;
  localparam int MAXP = (1 << 23) - 1;
  localparam real PI  = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst, ce, in_valid, inverse;
  logic [MAXL-1:0] k;
  logic [3:0]    log2n;
  logic          out_valid, out_err;
  logic [DW-1:0] tw;

  twiddle_quarter_gen #(.MAX_LOG2N(MAXL), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .i_ce(ce), .i_in_valid(in_valid), .i_k(k),
    .i_log2n(log2n), .i_inverse(inverse), .o_out_valid(out_valid),
    .o_twiddle_q(tw), .o_out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kk; int l2; bit inv; int issue; int tol; bit sweep; bit has_lit; logic [DW-1:0] lit;
  } req_t;

  req_t q[$];
  int ncmp = 0, nfail = 0;
  int cecyc = 0;
  bit last_ce = 1'b0;
  logic [DW-1:0] prev_tw = '0;
  logic prev_vld = 1'b0;
  int cur_tol = 0;
  bit cur_sweep = 1'b0, cur_has_lit = 1'b0;
  logic [DW-1:0] cur_lit = '0;

  task automatic chk_val(string tag, logic [63:0] obs, logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_near(string tag, int obs, int exp, int tol);
    int d;
    d = (obs > exp) ? obs - exp : exp - obs;
    ncmp++;
    assert (d <= tol) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int qz(real x);
    int v;
    v = $rtoi(x * 8388608.0 + ((x >= 0.0) ? 0.5 : -0.5));
    if (v > MAXP)  v = MAXP;
    if (v < -MAXP) v = -MAXP;
    return v;
  endfunction

  // Floating-point reference: W_N^k = cos(2pi k/N) - j sin(2pi k/N)
  function automatic void model(input int kk, input int l2, input bit inv,
                                output int re, output int im, output bit err);
    int L, n, km;
    real th;
    L   = (l2 < 2) ? 2 : ((l2 > MAXL) ? MAXL : l2);
    err = (l2 < 2) || (l2 > MAXL);
    n   = 1 << L;
    km  = kk % n;
    th  = 2.0 * PI * real'(km) / real'(n);
    re  = qz($cos(th));
    im  = -qz($sin(th));
    if (inv) im = -im;
  endfunction

  // Request acceptance bookkeeping (inputs change #1 after posedge)
  always @(posedge clk) begin
    if (rst) begin
      last_ce <= 1'b0;
    end else begin
      last_ce <= ce;
      if (ce && in_valid)
        q.push_back('{int'(k), int'(log2n), inverse, cecyc, cur_tol, cur_sweep, cur_has_lit, cur_lit});
      if (ce) cecyc <= cecyc + 1;
    end
  end

  req_t r;
  int e_re, e_im, o_re, o_im;
  bit e_err;
  real a, b, mag;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else if (last_ce && out_valid) begin
      chk_val("output_has_request", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        r = q.pop_front();
        model(r.kk, r.l2, r.inv, e_re, e_im, e_err);
        o_re = int'($signed(tw[47:24]));
        o_im = int'($signed(tw[23:0]));
        chk_val("latency", 64'(cecyc - r.issue), 64'd3);
        chk_val("out_err", 64'(out_err), 64'(e_err));
        chk_near("re", o_re, e_re, r.tol);
        chk_near("im", o_im, e_im, r.tol);
        if (r.has_lit) chk_val("literal_word", 64'(tw), 64'(r.lit));
        if (r.sweep) begin
          a   = real'(o_re) / 8388608.0;
          b   = real'(o_im) / 8388608.0;
          mag = a * a + b * b - 1.0;
          if (mag < 0.0) mag = -mag;
          chk_val("magnitude", 64'(mag <= 1.0 / 1048576.0), 64'd1);
          if (e_re >= 2 || e_re <= -2) chk_val("sign_re", 64'(o_re < 0), 64'(e_re < 0));
          if (e_im >= 2 || e_im <= -2) chk_val("sign_im", 64'(o_im < 0), 64'(e_im < 0));
        end
      end
    end else begin
      chk_val("hold_twiddle", 64'(tw), 64'(prev_tw));
      if (!last_ce) chk_val("hold_valid", 64'(out_valid), 64'(prev_vld));
      if (last_ce && q.size() > 0)
        chk_val("no_drop", 64'((cecyc - q[0].issue) < 3), 64'd1);
    end
    prev_tw  <= tw;
    prev_vld <= out_valid;
  end

  // One clock of stimulus: drive now, advance to 1 time unit past the edge
  task automatic step(bit v, int kk, int l2, bit inv, bit cev, int tol,
                      bit hl, logic [DW-1:0] lit, bit sw);
    in_valid    = v;
    k           = kk[MAXL-1:0];
    log2n       = l2[3:0];
    inverse     = inv;
    ce          = cev;
    cur_tol     = tol;
    cur_has_lit = hl;
    cur_lit     = lit;
    cur_sweep   = sw;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 9, 1'b0, 1'b1, 0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; in_valid = 1'b0; k = '0; log2n = 4'd9; inverse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_val("reset_out_valid", 64'(out_valid), 64'd0);
    chk_val("reset_twiddle", 64'(tw), 64'd0);
    chk_val("reset_out_err", 64'(out_err), 64'd0);
    rst = 1'b0;

    // Directed N=512 forward / inverse, runtime size, clamping
    step(1, 0,   9, 0, 1, 0, 1, 48'h7FFFFF_000000, 0);
    step(1, 128, 9, 0, 1, 0, 1, 48'h000000_800001, 0);
    step(1, 256, 9, 0, 1, 0, 1, 48'h800001_000000, 0);
    step(1, 384, 9, 0, 1, 0, 1, 48'h000000_7FFFFF, 0);
    step(1, 128, 9, 1, 1, 0, 1, 48'h000000_7FFFFF, 0);
    step(1, 64,  9, 1, 1, 1, 0, '0, 0);
    step(1, 4,   4, 0, 1, 0, 1, 48'h000000_800001, 0);
    step(1, 20,  4, 0, 1, 0, 1, 48'h000000_800001, 0);
    step(1, 100, 12, 0, 1, 1, 0, '0, 0);
    step(1, 5,   0, 0, 1, 1, 0, '0, 0);
    step(1, 511, 1, 1, 1, 1, 0, '0, 0);
    step(1, 511, 9, 0, 1, 1, 0, '0, 0);
    idle(5);

    // Reset with requests in flight: outputs clear at once, nothing stale later
    step(1, 1, 9, 0, 1, 1, 0, '0, 0);
    step(1, 2, 9, 0, 1, 1, 0, '0, 0);
    step(1, 3, 9, 0, 1, 1, 0, '0, 0);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk_val("async_reset_out_valid", 64'(out_valid), 64'd0);
    chk_val("async_reset_twiddle", 64'(tw), 64'd0);
    chk_val("async_reset_out_err", 64'(out_err), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(8);

    // Stall: k=0..31 back-to-back with pseudo-random ce
    for (int kk = 0; kk < 32; kk++) begin
      automatic bit inv = 1'($urandom_range(0, 1));
      for (int t = 0; t < 32; t++) begin
        automatic bit cev = (t >= 16) ? 1'b1 : 1'($urandom_range(0, 1));
        step(1, kk, 9, inv, cev, 1, 0, '0, 0);
        if (cev) break;
      end
    end
    idle(5);

    // Random traffic: gaps, ce stalls, any log2n including out-of-range
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 511)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1, 0, '0, 0);
    idle(5);

    // Sweep every k for log2n 3..9 in both directions
    for (int l2 = 3; l2 <= 9; l2++)
      for (int inv = 0; inv < 2; inv++)
        for (int kk = 0; kk < (1 << l2); kk++)
          step(1, kk, l2, inv[0], 1, 1, 0, '0, 1);

    for (int t = 0; t < 20 && q.size() > 0; t++) idle(1);
    chk_val("drain_empty", 64'(q.size()), 64'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
